// File: rtl/jtag_pkg.sv
// ============================================================================
// jtag_pkg : shared TAP state encoding, opcodes and data-register selects
// Rev 1.0
// ============================================================================
`default_nettype none

package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        P_DR   = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        P_IR   = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

    // Opcodes are zero-extended to IR_W; BYPASS is all ones at any width.
    localparam int OP_EXTEST = 0;
    localparam int OP_SAMPLE = 1;
    localparam int OP_IDCODE = 2;

    typedef enum logic [1:0] {
        BYP = 2'd0,
        IDC = 2'd1,
        BSR = 2'd2
    } dr_sel_t;

    function automatic logic is_shift_state(input tap_state_t s);
        return (s == SH_DR) || (s == SH_IR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
// ============================================================================
// jtag_tap_fsm : 16-state TAP controller, advances once per advance pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       tms,
    output logic [3:0] state
);

    tap_state_t r_state;
    tap_state_t w_next;

    always_comb begin
        w_next = TLR;
        case (r_state)
            TLR:     w_next = tms ? TLR    : RTI;
            RTI:     w_next = tms ? SEL_DR : RTI;
            SEL_DR:  w_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:  w_next = tms ? EX1_DR : SH_DR;
            SH_DR:   w_next = tms ? EX1_DR : SH_DR;
            EX1_DR:  w_next = tms ? UPD_DR : P_DR;
            P_DR:    w_next = tms ? EX2_DR : P_DR;
            EX2_DR:  w_next = tms ? UPD_DR : SH_DR;
            UPD_DR:  w_next = tms ? SEL_DR : RTI;
            SEL_IR:  w_next = tms ? TLR    : CAP_IR;
            CAP_IR:  w_next = tms ? EX1_IR : SH_IR;
            SH_IR:   w_next = tms ? EX1_IR : SH_IR;
            EX1_IR:  w_next = tms ? UPD_IR : P_IR;
            P_IR:    w_next = tms ? EX2_IR : P_IR;
            EX2_IR:  w_next = tms ? UPD_IR : SH_IR;
            UPD_IR:  w_next = tms ? SEL_DR : RTI;
            default: w_next = TLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= TLR;
        end else if (advance) begin
            r_state <= w_next;
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire

// File: rtl/jtag_tap_sampled.sv
// ============================================================================
// jtag_tap_sampled : oversampled 1149.1 TAP with IR, BYPASS, IDCODE and BSR
// Optional IDCODE register enabled by macro JTAG_IDCODE_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module jtag_tap_sampled
    import jtag_pkg::*;
#(
    parameter int          IR_W        = 4,
    parameter int          BSR_W       = 8,
    parameter logic [31:0] IDCODE_VAL  = 32'h1000_0A5B,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tck,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             tdo_oe,
    input  logic [BSR_W-1:0] pin_in,
    input  logic [BSR_W-1:0] core_out,
    output logic [BSR_W-1:0] pin_out,
    output logic             extest_active,
    output logic [3:0]       tap_state
);

    localparam logic [IR_W-1:0] C_OP_EXTEST = IR_W'(OP_EXTEST);
    localparam logic [IR_W-1:0] C_OP_SAMPLE = IR_W'(OP_SAMPLE);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] C_OP_IDCODE = IR_W'(OP_IDCODE);
    localparam logic [IR_W-1:0] C_IR_RESET  = C_OP_IDCODE;
`else
    localparam logic [IR_W-1:0] C_IR_RESET  = '1;
`endif

    generate
        if (IDCODE_VAL[0] != 1'b1 || IR_W < 2 || SYNC_STAGES < 2) begin : g_param_check
            $error("jtag_tap_sampled: illegal parameter combination");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_tck_sync;
    logic [SYNC_STAGES-1:0] r_tms_sync;
    logic [SYNC_STAGES-1:0] r_tdi_sync;
    logic                   r_tck_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tck_sync <= '0;
            r_tms_sync <= '0;
            r_tdi_sync <= '0;
            r_tck_last <= 1'b0;
        end else begin
            r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], tck};
            r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], tms};
            r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], tdi};
            r_tck_last <= r_tck_sync[SYNC_STAGES-1];
        end
    end

    logic w_tck_rise;
    logic w_tck_fall;
    logic w_tms_s;
    logic w_tdi_s;

    assign w_tck_rise =  r_tck_sync[SYNC_STAGES-1] & ~r_tck_last;
    assign w_tck_fall = ~r_tck_sync[SYNC_STAGES-1] &  r_tck_last;
    assign w_tms_s    =  r_tms_sync[SYNC_STAGES-1];
    assign w_tdi_s    =  r_tdi_sync[SYNC_STAGES-1];

    logic [3:0] w_state_raw;
    tap_state_t w_state;

    jtag_tap_fsm u_fsm (
        .clk     (clk),
        .reset   (reset),
        .advance (w_tck_rise),
        .tms     (w_tms_s),
        .state   (w_state_raw)
    );

    assign w_state   = tap_state_t'(w_state_raw);
    assign tap_state = w_state_raw;

    logic [IR_W-1:0]  r_ir_sr;
    logic [IR_W-1:0]  r_ir;
    logic             r_byp;
    logic [BSR_W-1:0] r_bsr_sr;
    logic [BSR_W-1:0] r_bsr_upd;
    logic             r_extest;
    logic             r_tdo;
    logic             r_tdo_oe;
    dr_sel_t          w_sel;
    logic             w_idc_lsb;
    logic             w_dr_lsb;

    always_comb begin
        w_sel = BYP;
        if (r_ir == C_OP_EXTEST || r_ir == C_OP_SAMPLE) begin
            w_sel = BSR;
        end
`ifdef JTAG_IDCODE_EN
        else if (r_ir == C_OP_IDCODE) begin
            w_sel = IDC;
        end
`endif
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] r_idc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idc <= '0;
        end else if (w_tck_rise && w_sel == IDC) begin
            if (w_state == CAP_DR) begin
                r_idc <= IDCODE_VAL;
            end else if (w_state == SH_DR) begin
                r_idc <= {w_tdi_s, r_idc[31:1]};
            end
        end
    end

    assign w_idc_lsb = r_idc[0];
`else
    assign w_idc_lsb = 1'b0;
`endif

    always_comb begin
        w_dr_lsb = r_byp;
        case (w_sel)
            IDC:     w_dr_lsb = w_idc_lsb;
            BSR:     w_dr_lsb = r_bsr_sr[0];
            default: w_dr_lsb = r_byp;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_sr   <= '0;
            r_ir      <= C_IR_RESET;
            r_byp     <= 1'b0;
            r_bsr_sr  <= '0;
            r_bsr_upd <= '0;
            r_extest  <= 1'b0;
            r_tdo     <= 1'b0;
            r_tdo_oe  <= 1'b0;
        end else begin
            // Holding TLR keeps the instruction parked; bsr_update is left alone.
            if (w_state == TLR) begin
                r_ir     <= C_IR_RESET;
                r_extest <= 1'b0;
            end
            if (w_tck_rise) begin
                case (w_state)
                    CAP_IR: r_ir_sr <= IR_W'(2'b01);
                    SH_IR:  r_ir_sr <= {w_tdi_s, r_ir_sr[IR_W-1:1]};
                    UPD_IR: begin
                        r_ir     <= r_ir_sr;
                        r_extest <= (r_ir_sr == C_OP_EXTEST);
                    end
                    CAP_DR: begin
                        if (w_sel == BYP) r_byp    <= 1'b0;
                        if (w_sel == BSR) r_bsr_sr <= pin_in;
                    end
                    SH_DR: begin
                        if (w_sel == BYP) r_byp    <= w_tdi_s;
                        if (w_sel == BSR) r_bsr_sr <= {w_tdi_s, r_bsr_sr[BSR_W-1:1]};
                    end
                    UPD_DR: begin
                        if (w_sel == BSR) r_bsr_upd <= r_bsr_sr;
                    end
                    default: ;
                endcase
            end
            if (w_tck_fall) begin
                if (w_state == SH_IR) begin
                    r_tdo <= r_ir_sr[0];
                end else if (w_state == SH_DR) begin
                    r_tdo <= w_dr_lsb;
                end
                r_tdo_oe <= is_shift_state(w_state);
            end
        end
    end

    assign tdo           = r_tdo;
    assign tdo_oe        = r_tdo_oe;
    assign extest_active = r_extest;
    assign pin_out       = r_extest ? r_bsr_upd : core_out;

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_sampled.sv
// ============================================================================
// tb_jtag_tap_sampled : directed + randomized TAP scans against a TAP model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jtag_tap_sampled;

    localparam logic [31:0] IDC = 32'h1000_0A5B;
`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] RST_IR = 4'b0010;
`else
    localparam logic [3:0] RST_IR = 4'b1111;
`endif

    logic       clk = 1'b0;
    logic       reset, tck, tms, tdi;
    logic       tdo, tdo_oe, extest_active;
    logic [7:0] pin_in, core_out, pin_out;
    logic [3:0] tap_state;

    jtag_tap_sampled dut (
        .clk           (clk),
        .reset         (reset),
        .tck           (tck),
        .tms           (tms),
        .tdi           (tdi),
        .tdo           (tdo),
        .tdo_oe        (tdo_oe),
        .pin_in        (pin_in),
        .core_out      (core_out),
        .pin_out       (pin_out),
        .extest_active (extest_active),
        .tap_state     (tap_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // TAP graph as lookup tables indexed by 1149.1 state code
    int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    int          m_state, m_len, m_sel;
    logic [3:0]  m_ir_sr, m_ir;
    logic [63:0] m_dr;
    logic [7:0]  m_upd;
    logic        m_ext, m_tdo, m_oe;

    function automatic int sel_of(input logic [3:0] ir);
        if (ir == 4'b0000 || ir == 4'b0001) return 2;
`ifdef JTAG_IDCODE_EN
        if (ir == 4'b0010) return 1;
`endif
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 15; m_ir_sr = '0; m_ir = RST_IR; m_dr = '0; m_len = 1; m_sel = 0;
        m_upd = '0; m_ext = 1'b0; m_tdo = 1'b0; m_oe = 1'b0;
    endtask

    task automatic step(input logic t_ms, input logic t_di);
        tms = t_ms;
        tdi = t_di;
        repeat (4) @(posedge clk);
        #1 tck = 1'b1;
        case (m_state)
            14: m_ir_sr = 4'b0001;
            10: m_ir_sr = {t_di, m_ir_sr[3:1]};
            13: begin m_ir = m_ir_sr; m_ext = (m_ir_sr == 4'b0000); end
            6: begin
                m_sel = sel_of(m_ir);
                if (m_sel == 1)      begin m_dr = 64'(IDC);    m_len = 32; end
                else if (m_sel == 2) begin m_dr = 64'(pin_in); m_len = 8;  end
                else                 begin m_dr = '0;          m_len = 1;  end
            end
            2: m_dr = (m_dr >> 1) | (64'(t_di) << (m_len - 1));
            5: if (m_sel == 2) m_upd = m_dr[7:0];
            default: ;
        endcase
        m_state = t_ms ? nxt1[m_state] : nxt0[m_state];
        if (m_state == 15) begin m_ir = RST_IR; m_ext = 1'b0; end
        repeat (6) @(posedge clk);
        #1;
        chk("tap_state", 64'(tap_state), 64'(m_state));
        chk("extest_active", 64'(extest_active), 64'(m_ext));
        chk("pin_out", 64'(pin_out), 64'(m_ext ? m_upd : core_out));
        tck = 1'b0;
        if (m_state == 10)     m_tdo = m_ir_sr[0];
        else if (m_state == 2) m_tdo = m_dr[0];
        m_oe = (m_state == 10) || (m_state == 2);
        repeat (6) @(posedge clk);
        #1;
        chk("tdo", 64'(tdo), 64'(m_tdo));
        chk("tdo_oe", 64'(tdo_oe), 64'(m_oe));
    endtask

    // Full scan from RTI back to RTI; dout collects tdo LSB-first.
    task automatic scan(input logic ir, input logic [63:0] din, input int n,
                        output logic [63:0] dout);
        dout = '0;
        step(1'b1, 1'b0);
        if (ir) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        dout[0] = tdo;
        for (int i = 0; i < n - 1; i++) begin
            step(1'b0, din[i]);
            dout[i+1] = tdo;
        end
        step(1'b1, din[n-1]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    function automatic int len_of(input logic [3:0] ir);
        int s;
        s = sel_of(ir);
        return (s == 1) ? 32 : (s == 2) ? 8 : 1;
    endfunction

    logic [63:0] d, r;
    logic [3:0]  op;

    initial begin
        tck = 1'b0; tms = 1'b1; tdi = 1'b0; reset = 1'b1;
        pin_in = 8'($urandom); core_out = 8'h5A;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("reset_state", 64'(tap_state), 64'hF);
        chk("reset_tdo", 64'(tdo), 64'h0);
        chk("reset_tdo_oe", 64'(tdo_oe), 64'h0);
        chk("reset_extest", 64'(extest_active), 64'h0);
        chk("reset_pin_out", 64'(pin_out), 64'h5A);

        step(1'b0, 1'b0);
        scan(1'b0, 64'($urandom), 32, d);
`ifdef JTAG_IDCODE_EN
        chk("idcode_stream", d[31:0], 64'(IDC));
`else
        chk("reset_bypass_first", 64'(d[0]), 64'h0);
`endif

        scan(1'b1, 64'hF, 4, d);
        chk("ir_capture", 64'(d[3:0]), 64'h1);
        scan(1'b0, 64'b1101, 4, d);
        chk("bypass_delay", 64'(d[3:0]), 64'b1010);

        scan(1'b1, 64'h1, 4, d);
        pin_in = 8'hC3;
        scan(1'b0, 64'($urandom), 8, d);
        chk("sample_stream", 64'(d[7:0]), 64'hC3);
        chk("sample_pin_out", 64'(pin_out), 64'h5A);

        scan(1'b0, 64'hA5, 8, d);
        scan(1'b1, 64'h0, 4, d);
        chk("extest_on", 64'(extest_active), 64'h1);
        chk("extest_pin_out", 64'(pin_out), 64'hA5);
        r = 64'($urandom_range(255));
        scan(1'b0, r, 8, d);
        chk("extest_update", 64'(pin_out), 64'(r[7:0]));
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("tlr_extest_off", 64'(extest_active), 64'h0);
        chk("tlr_pin_out", 64'(pin_out), 64'(core_out));
        step(1'b0, 1'b0);

        // Reset in the middle of an IR shift of EXTEST
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        chk("midshift_reset_state", 64'(tap_state), 64'hF);
        chk("midshift_extest", 64'(extest_active), 64'h0);
        chk("midshift_tdo", 64'(tdo), 64'h0);
        step(1'b0, 1'b0);
        scan(1'b0, 64'($urandom), 32, d);
`ifdef JTAG_IDCODE_EN
        chk("post_reset_idcode", d[31:0], 64'(IDC));
`else
        chk("post_reset_bypass", 64'(d[0]), 64'h0);
`endif

        scan(1'b1, 64'h2, 4, d);
        scan(1'b0, 64'b0111, 4, d);
`ifdef JTAG_IDCODE_EN
        chk("op0010_stream", 64'(d[3:0]), 64'(IDC[3:0]));
`else
        chk("op0010_bypass", 64'(d[3:0]), 64'b1110);
`endif

        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(4))
                0: op = 4'b0000;
                1: op = 4'b0001;
                2: op = 4'b0010;
                3: op = 4'b1111;
                default: op = 4'($urandom);
            endcase
            core_out = 8'($urandom);
            scan(1'b1, 64'(op), 4, d);
            chk("rand_ir_capture", 64'(d[3:0]), 64'h1);
            pin_in = 8'($urandom);
            r = {32'($urandom), 32'($urandom)};
            scan(1'b0, r, len_of(op), d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
